// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory-bus arbiter.
package cache_mem_arbiter_pkg;

  localparam int unsigned ADDR_BUS_W = 64;
  localparam int unsigned DATA_BUS_W = 64;
  localparam int unsigned STARVE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Saturating increment for the starve counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == '1) ? v : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_prio.sv
// Fixed data-over-instruction priority pick with a starvation guard for the I port.
module arb_prio_starve
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arb_en,
  input  logic                i_req,
  input  logic                d_req,
  output logic                gnt_c,
  output req_id_e             gnt_id_c,
  output logic [STARVE_W-1:0] starve_cnt_o
);

  always_comb begin
    gnt_c    = 1'b0;
    gnt_id_c = REQ_D;
    if (arb_en) begin
      if (i_req && (starve_cnt_o == STARVE_W'(STARVE_LIMIT))) begin
        gnt_c    = 1'b1;
        gnt_id_c = REQ_I;
      end else if (d_req) begin
        gnt_c    = 1'b1;
        gnt_id_c = REQ_D;
      end else if (i_req) begin
        gnt_c    = 1'b1;
        gnt_id_c = REQ_I;
      end
    end
  end

  // Counts D grants that overtook a waiting I request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_o <= '0;
    end else if (gnt_c && (gnt_id_c == REQ_I)) begin
      starve_cnt_o <= '0;
    end else if (gnt_c && i_req) begin
      starve_cnt_o <= sat_inc(starve_cnt_o);
    end else if (arb_en && !i_req) begin
      starve_cnt_o <= '0;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the instruction-fetch and data request ports,
// with registered payload, starvation guard and a response timeout.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_BUS_W,
  parameter int unsigned DATA_W       = DATA_BUS_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_wen_i,
  input  logic [DATA_W-1:0] i_wdata_i,
  output logic              i_resp_valid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_valid_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_wen_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_resp_valid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              resp_err_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  arb_state_e          state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                mem_req_d, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                i_resp_d, d_resp_d, resp_err_d;
  logic [DATA_W-1:0]   i_rdata_d, d_rdata_d;

  logic                arb_en;
  logic                gnt_c;
  req_id_e             gnt_id_c;
  logic [STARVE_W-1:0] starve_cnt;
  logic                tmo_hit;
  logic                finish;
  logic [DATA_W-1:0]   fin_rdata;

  assign arb_en  = (state_q == IDLE);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_W'(TMO_LAST));

  arb_prio_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .arb_en       (arb_en),
    .i_req        (i_req_valid_i),
    .d_req        (d_req_valid_i),
    .gnt_c        (gnt_c),
    .gnt_id_c     (gnt_id_c),
    .starve_cnt_o (starve_cnt)
  );

  // Completion of the granted transaction: a real response beats a same-cycle timeout.
  always_comb begin
    finish    = 1'b0;
    fin_rdata = '0;
    if (mem_resp_valid_i) begin
      finish    = 1'b1;
      fin_rdata = mem_rdata_i;
    end else if (tmo_hit) begin
      finish    = 1'b1;
    end
  end

  // Next-state and next-output logic; every output is captured by the register below.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_valid_o;
    mem_addr_d  = mem_addr_o;
    mem_wen_d   = mem_wen_o;
    mem_wdata_d = mem_wdata_o;
    i_rdata_d   = i_rdata_o;
    d_rdata_d   = d_rdata_o;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    resp_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_c) begin
          mem_req_d = 1'b1;
          tmo_d     = '0;
          if (gnt_id_c == REQ_I) begin
            state_d     = GNT_I;
            mem_addr_d  = i_addr_i;
            mem_wen_d   = i_wen_i;
            mem_wdata_d = i_wdata_i;
          end else begin
            state_d     = GNT_D;
            mem_addr_d  = d_addr_i;
            mem_wen_d   = d_wen_i;
            mem_wdata_d = d_wdata_i;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (finish) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          resp_err_d = !mem_resp_valid_i;
          if (state_q == GNT_I) begin
            i_resp_d  = 1'b1;
            i_rdata_d = fin_rdata;
          end else begin
            d_resp_d  = 1'b1;
            d_rdata_d = fin_rdata;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      tmo_q           <= '0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      mem_wen_o       <= 1'b0;
      mem_wdata_o     <= '0;
      i_resp_valid_o  <= 1'b0;
      i_rdata_o       <= '0;
      d_resp_valid_o  <= 1'b0;
      d_rdata_o       <= '0;
      resp_err_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_q           <= tmo_d;
      mem_req_valid_o <= mem_req_d;
      mem_addr_o      <= mem_addr_d;
      mem_wen_o       <= mem_wen_d;
      mem_wdata_o     <= mem_wdata_d;
      i_resp_valid_o  <= i_resp_d;
      i_rdata_o       <= i_rdata_d;
      d_resp_valid_o  <= d_resp_d;
      d_rdata_o       <= d_rdata_d;
      resp_err_o      <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req_valid_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic          i_wen_i = 1'b0;
  logic [DW-1:0] i_wdata_i = '0;
  logic          i_resp_valid_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_req_valid_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic          d_wen_i = 1'b0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_resp_valid_o;
  logic [DW-1:0] d_rdata_o;
  logic          resp_err_o;
  logic          mem_req_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_wen_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_resp_valid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  int checks = 0;
  int passed = 0;

  cache_mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (4),
    .TIMEOUT      (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid_i    (i_req_valid_i),
    .i_addr_i         (i_addr_i),
    .i_wen_i          (i_wen_i),
    .i_wdata_i        (i_wdata_i),
    .i_resp_valid_o   (i_resp_valid_o),
    .i_rdata_o        (i_rdata_o),
    .d_req_valid_i    (d_req_valid_i),
    .d_addr_i         (d_addr_i),
    .d_wen_i          (d_wen_i),
    .d_wdata_i        (d_wdata_i),
    .d_resp_valid_o   (d_resp_valid_o),
    .d_rdata_o        (d_rdata_o),
    .resp_err_o       (resp_err_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wen_o        (mem_wen_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the arbiter raises a memory request, bounded.
  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (mem_req_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // One-cycle memory completion; rdata is scrambled afterwards so late capture shows up.
  task automatic mem_respond(input logic [DW-1:0] data);
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = data;
    tick();
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_req_valid_o !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req_valid_o); else passed++;
    checks++; if ({i_resp_valid_o, d_resp_valid_o, resp_err_o} !== 3'b000) $display("FAIL reset_resp got %b want 000", {i_resp_valid_o, d_resp_valid_o, resp_err_o}); else passed++;
    checks++; if (mem_addr_o !== 64'h0) $display("FAIL reset_addr got %h want 0", mem_addr_o); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_i_only();
    i_req_valid_i = 1'b1;
    i_addr_i      = 64'h8000_0000;
    checks++; if (mem_req_valid_o !== 1'b0) $display("FAIL i_only_pre_req got %b want 0", mem_req_valid_o); else passed++;
    tick();
    checks++; if (mem_req_valid_o !== 1'b1) $display("FAIL i_only_latency got %b want 1", mem_req_valid_o); else passed++;
    checks++; if (mem_addr_o !== 64'h8000_0000) $display("FAIL i_only_addr got %h want 80000000", mem_addr_o); else passed++;
    tick();
    tick();
    checks++; if (mem_req_valid_o !== 1'b1) $display("FAIL i_only_hold got %b want 1", mem_req_valid_o); else passed++;
    mem_respond(64'h13);
    i_req_valid_i = 1'b0;
    checks++; if (i_resp_valid_o !== 1'b1) $display("FAIL i_only_resp got %b want 1", i_resp_valid_o); else passed++;
    checks++; if (i_rdata_o !== 64'h13) $display("FAIL i_only_rdata got %h want 13", i_rdata_o); else passed++;
    checks++; if ({resp_err_o, d_resp_valid_o, mem_req_valid_o} !== 3'b000) $display("FAIL i_only_side got %b want 000", {resp_err_o, d_resp_valid_o, mem_req_valid_o}); else passed++;
    tick();
    checks++; if (i_resp_valid_o !== 1'b0) $display("FAIL i_only_pulse_width got %b want 0", i_resp_valid_o); else passed++;
  endtask

  task automatic test_priority();
    i_req_valid_i = 1'b1;
    i_addr_i      = 64'h100;
    d_req_valid_i = 1'b1;
    d_addr_i      = 64'h200;
    tick();
    checks++; if (mem_addr_o !== 64'h200) $display("FAIL prio_d_first got %h want 200", mem_addr_o); else passed++;
    mem_respond(64'hD1);
    d_req_valid_i = 1'b0;
    checks++; if ({d_resp_valid_o, i_resp_valid_o} !== 2'b10) $display("FAIL prio_d_resp got %b want 10", {d_resp_valid_o, i_resp_valid_o}); else passed++;
    checks++; if (d_rdata_o !== 64'hD1) $display("FAIL prio_d_rdata got %h want d1", d_rdata_o); else passed++;
    tick();
    checks++; if (mem_req_valid_o !== 1'b0) $display("FAIL prio_gap got %b want 0", mem_req_valid_o); else passed++;
    tick();
    checks++; if ({mem_req_valid_o, mem_addr_o} !== {1'b1, 64'h100}) $display("FAIL prio_i_second got %b/%h want 1/100", mem_req_valid_o, mem_addr_o); else passed++;
    mem_respond(64'h11);
    i_req_valid_i = 1'b0;
    checks++; if ({i_resp_valid_o, i_rdata_o} !== {1'b1, 64'h11}) $display("FAIL prio_i_resp got %b/%h want 1/11", i_resp_valid_o, i_rdata_o); else passed++;
    tick();
  endtask

  task automatic test_starve();
    bit ok;
    logic [AW-1:0] exp_addr;
    d_req_valid_i = 1'b1;
    d_addr_i      = 64'h300;
    i_req_valid_i = 1'b1;
    i_addr_i      = 64'h400;
    for (int g = 0; g < 5; g++) begin
      wait_mem_req(ok);
      checks++; if (!ok) $display("FAIL starve_grant%0d_timeout got no request want request", g); else passed++;
      exp_addr = (g < 4) ? 64'h300 : 64'h400;
      checks++; if (mem_addr_o !== exp_addr) $display("FAIL starve_grant%0d_addr got %h want %h", g, mem_addr_o, exp_addr); else passed++;
      if (g == 3) begin
        checks++; if (dut.u_arb.starve_cnt_o !== 4'd4) $display("FAIL starve_cnt_at_limit got %0d want 4", dut.u_arb.starve_cnt_o); else passed++;
      end
      mem_respond(DW'(g));
      if (g < 4) begin
        checks++; if (d_resp_valid_o !== 1'b1) $display("FAIL starve_d_resp%0d got %b want 1", g, d_resp_valid_o); else passed++;
      end else begin
        checks++; if (i_resp_valid_o !== 1'b1) $display("FAIL starve_i_resp got %b want 1", i_resp_valid_o); else passed++;
        i_req_valid_i = 1'b0;
        d_req_valid_i = 1'b0;
      end
      tick();
    end
    checks++; if (dut.u_arb.starve_cnt_o !== 4'd0) $display("FAIL starve_cnt_clear got %0d want 0", dut.u_arb.starve_cnt_o); else passed++;
  endtask

  task automatic test_write();
    bit ok;
    d_req_valid_i = 1'b1;
    d_addr_i      = 64'h1000;
    d_wen_i       = 1'b1;
    d_wdata_i     = 64'hDEAD_BEEF;
    wait_mem_req(ok);
    checks++; if (!ok) $display("FAIL write_req_timeout got no request want request"); else passed++;
    checks++; if ({mem_wen_o, mem_wdata_o} !== {1'b1, 64'hDEAD_BEEF}) $display("FAIL write_payload got %b/%h want 1/deadbeef", mem_wen_o, mem_wdata_o); else passed++;
    d_wdata_i = 64'h1234_5678;
    d_addr_i  = 64'h0;
    tick();
    tick();
    checks++; if ({mem_req_valid_o, mem_wdata_o, mem_addr_o} !== {1'b1, 64'hDEAD_BEEF, 64'h1000}) $display("FAIL write_latched got %b/%h/%h want 1/deadbeef/1000", mem_req_valid_o, mem_wdata_o, mem_addr_o); else passed++;
    mem_respond(64'hACCE55);
    d_req_valid_i = 1'b0;
    d_wen_i       = 1'b0;
    checks++; if ({d_resp_valid_o, resp_err_o, mem_req_valid_o} !== 3'b100) $display("FAIL write_ack got %b want 100", {d_resp_valid_o, resp_err_o, mem_req_valid_o}); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    d_req_valid_i = 1'b1;
    d_addr_i      = 64'h2000;
    wait_mem_req(ok);
    checks++; if (!ok) $display("FAIL timeout_req got no request want request"); else passed++;
    n = 0;
    while (mem_req_valid_o === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    checks++; if (n != 8) $display("FAIL timeout_len got %0d want 8", n); else passed++;
    checks++; if ({d_resp_valid_o, resp_err_o} !== 2'b11) $display("FAIL timeout_err_resp got %b want 11", {d_resp_valid_o, resp_err_o}); else passed++;
    checks++; if (d_rdata_o !== 64'h0) $display("FAIL timeout_rdata got %h want 0", d_rdata_o); else passed++;
    d_req_valid_i = 1'b0;
    tick();
    checks++; if ({d_resp_valid_o, resp_err_o} !== 2'b00) $display("FAIL timeout_err_clear got %b want 00", {d_resp_valid_o, resp_err_o}); else passed++;
  endtask

  task automatic test_timeout_race();
    bit ok;
    d_req_valid_i = 1'b1;
    d_addr_i      = 64'h2100;
    wait_mem_req(ok);
    checks++; if (!ok) $display("FAIL race_req got no request want request"); else passed++;
    repeat (7) tick();
    mem_respond(64'h55);
    checks++; if ({d_resp_valid_o, resp_err_o} !== 2'b10) $display("FAIL race_resp_wins got %b want 10", {d_resp_valid_o, resp_err_o}); else passed++;
    checks++; if (d_rdata_o !== 64'h55) $display("FAIL race_rdata got %h want 55", d_rdata_o); else passed++;
    d_req_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_stray_resp();
    mem_respond(64'hFFFF);
    checks++; if ({i_resp_valid_o, d_resp_valid_o} !== 2'b00) $display("FAIL stray_resp got %b want 00", {i_resp_valid_o, d_resp_valid_o}); else passed++;
    tick();
    checks++; if (dut.state_q !== IDLE) $display("FAIL stray_state got %0d want 0", dut.state_q); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int resp_seen;
    d_req_valid_i = 1'b1;
    d_addr_i      = 64'h3000;
    wait_mem_req(ok);
    checks++; if (!ok) $display("FAIL rstmid_req got no request want request"); else passed++;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if ({mem_req_valid_o, mem_addr_o} !== {1'b0, 64'h0}) $display("FAIL rstmid_async got %b/%h want 0/0", mem_req_valid_o, mem_addr_o); else passed++;
    checks++; if (d_rdata_o !== 64'h0) $display("FAIL rstmid_rdata got %h want 0", d_rdata_o); else passed++;
    d_req_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    mem_resp_valid_i = 1'b1;
    resp_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      mem_resp_valid_i = 1'b0;
      if (d_resp_valid_o === 1'b1 || mem_req_valid_o === 1'b1) resp_seen++;
    end
    checks++; if (resp_seen != 0) $display("FAIL rstmid_no_resp got %0d activity cycles want 0", resp_seen); else passed++;
    checks++; if (dut.state_q !== IDLE) $display("FAIL rstmid_state got %0d want 0", dut.state_q); else passed++;
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_priority();
    test_starve();
    test_write();
    test_timeout();
    test_timeout_race();
    test_stray_resp();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
